muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 30 +++
 rtl/md_div_core.sv | 65 ++++++
 rtl/muldiv_seq.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the sequential multiply/divide unit: opcode and funct7
// that identify an M-extension instruction, funct3 operation encodings, and
// the controller state encoding.
package muldiv_seq_pkg;

    localparam logic [6:0] MD_OPCODE = 7'b0110011;
    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // True when the instruction word is a register-register M-extension op.
    function automatic logic is_md_instr(input logic [31:0] instr);
        return (instr[6:0] == MD_OPCODE) && (instr[31:25] == MD_FUNCT7);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Unsigned restoring divider. A load pulse captures dividend/divisor
// magnitudes; XLEN iterations follow, one quotient bit per clock. count_done
// stays high once all bits are produced, until the next load or reset.
module md_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            count_done
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] quo_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] dvs_reg;
    logic [CW-1:0]   cnt_reg;
    logic            active_reg;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Trial subtraction: partial remainder shifted left with the next dividend bit.
    always_comb begin
        shifted = {rem_reg, quo_reg[XLEN-1]};
        diff    = shifted - {1'b0, dvs_reg};
    end

    // One restoring step per clock while bits remain.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_reg    <= '0;
            rem_reg    <= '0;
            dvs_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            quo_reg    <= dividend;
            rem_reg    <= '0;
            dvs_reg    <= divisor;
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg && (cnt_reg != CW'(XLEN))) begin
            // Borrow out of the top bit means the trial went negative: restore.
            if (!diff[XLEN]) begin
                rem_reg <= diff[XLEN-1:0];
                quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
            end else begin
                rem_reg <= shifted[XLEN-1:0];
                quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign quotient   = quo_reg;
    assign remainder  = rem_reg;
    assign count_done = active_reg && (cnt_reg == CW'(XLEN));

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension multiply/divide unit.
// Multiply is iterative shift-add on operand magnitudes with a sign fix-up on
// entry to DONE; divide uses the md_div_core restoring divider. Divide by zero
// and signed overflow skip iteration and finish one cycle after accept.
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiply
// with a single-cycle array product (MUL state lasts one cycle).
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            md_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    md_state_e         state_reg;
    logic [2:0]        f3_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic [2*XLEN-1:0] mcand_reg;
    logic [XLEN-1:0]   mplier_reg;
    logic [2*XLEN-1:0] prod_reg;
    logic [CW-1:0]     count_reg;
    logic [XLEN-1:0]   result_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [2:0]        f3_in;
    logic              accept;
    logic              a_signed_in;
    logic              b_signed_in;
    logic              a_neg_in;
    logic              b_neg_in;
    logic [XLEN-1:0]   a_mag_in;
    logic [XLEN-1:0]   b_mag_in;
    logic              div_zero_in;
    logic              div_ovf_in;
    logic              div_special_in;
    logic [XLEN-1:0]   special_res_in;
    logic              div_load;

    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic              div_count_done;

    logic [2*XLEN-1:0] mul_full;
    logic              mul_last;
    logic [2*XLEN-1:0] mul_signed;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   div_res;

    // Register-specifier and rd fields are not needed by this unit.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    assign md_req = is_md_instr(instr);
    assign f3_in  = instr[14:12];
    assign accept = (state_reg == ST_IDLE) && start && md_req && !kill;

    // Operand sign handling and the early-exit divide cases, decided at accept.
    always_comb begin
        // Divides: signed unless funct3[0]. Multiplies: MULHU is u*u, MULHSU has unsigned b.
        a_signed_in    = f3_in[2] ? !f3_in[0] : (f3_in[1:0] != 2'b11);
        b_signed_in    = f3_in[2] ? !f3_in[0] : !f3_in[1];
        a_neg_in       = a_signed_in && op_a[XLEN-1];
        b_neg_in       = b_signed_in && op_b[XLEN-1];
        a_mag_in       = a_neg_in ? -op_a : op_a;
        b_mag_in       = b_neg_in ? -op_b : op_b;
        div_zero_in    = (op_b == '0);
        div_ovf_in     = !f3_in[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);
        div_special_in = f3_in[2] && (div_zero_in || div_ovf_in);
        special_res_in = '0;
        if (div_zero_in) begin
            special_res_in = f3_in[1] ? op_a : ALL_ONES;
        end else begin
            special_res_in = f3_in[1] ? '0 : op_a;
        end
    end

    assign div_load = accept && f3_in[2] && !div_special_in;

    md_div_core #(
        .XLEN (XLEN)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .load       (div_load),
        .dividend   (a_mag_in),
        .divisor    (b_mag_in),
        .quotient   (div_quo),
        .remainder  (div_rem),
        .count_done (div_count_done)
    );

`ifdef MULDIV_FAST_MUL_EN
    assign mul_full = {{XLEN{1'b0}}, mcand_reg[XLEN-1:0]} * {{XLEN{1'b0}}, mplier_reg};
    assign mul_last = 1'b1;
`else
    assign mul_full = prod_reg;
    assign mul_last = (count_reg == CW'(XLEN));
`endif

    // Sign fix-up and result selection for the DONE entry cycle.
    always_comb begin
        mul_signed = neg_q_reg ? -mul_full : mul_full;
        mul_res    = (f3_reg == MD_MUL) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
        if (f3_reg[1]) begin
            div_res = neg_r_reg ? -div_rem : div_rem;
        end else begin
            div_res = neg_q_reg ? -div_quo : div_quo;
        end
    end

    // Controller with registered busy/done/result and the multiply datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            f3_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (kill) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        f3_reg    <= f3_in;
                        neg_q_reg <= a_neg_in ^ b_neg_in;
                        neg_r_reg <= a_neg_in;
                        busy_reg  <= 1'b1;
                        if (!f3_in[2]) begin
                            state_reg  <= ST_MUL;
                            mcand_reg  <= {{XLEN{1'b0}}, a_mag_in};
                            mplier_reg <= b_mag_in;
                            prod_reg   <= '0;
                            count_reg  <= '0;
                        end else if (div_special_in) begin
                            state_reg  <= ST_DONE;
                            result_reg <= special_res_in;
                            done_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state_reg  <= ST_DONE;
                        result_reg <= mul_res;
                        done_reg   <= 1'b1;
                    end else begin
                        if (mplier_reg[0]) begin
                            prod_reg <= prod_reg + mcand_reg;
                        end
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        count_reg  <= count_reg + CW'(1);
                    end
                end
                ST_DIV: begin
                    if (div_count_done) begin
                        state_reg  <= ST_DONE;
                        result_reg <= div_res;
                        done_reg   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq (XLEN=32): a transaction-level reference model
// predicts busy/done/result every cycle, and directed vectors carry
// hand-computed results and latencies.
module tb_muldiv_seq;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [31:0] instr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        md_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state: busy cycles left (0 = idle), shown and pending results.
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .instr  (instr),
        .op_a   (op_a),
        .op_b   (op_b),
        .md_req (md_req),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic m_is_md(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001);
    endfunction

    // Architectural result of each M-extension op, via 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [63:0] up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * $signed(ub); return p[63:32]; end
            3'b011: begin up = ua * ub; return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Busy cycles from accept to the done cycle inclusive.
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return DIV_LAT;
    endfunction

    // Reference model advance on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (kill) begin
            m_left <= 0;
        end else if (m_left == 0) begin
            if (start && m_is_md(instr)) begin
                m_left <= ref_lat(instr[14:12], op_a, op_b);
                m_pend <= ref_op(instr[14:12], op_a, op_b);
                if (ref_lat(instr[14:12], op_a, op_b) == 1)
                    m_res <= ref_op(instr[14:12], op_a, op_b);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_res <= m_pend;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency and result.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int k;
        bit seen;
        instr = mk_instr(f3);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'h1234_5678;
        k     = 0;
        seen  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_latency"}, seen ? k : -1, exp_lat);
        chk({name, "_result"}, result, exp_r);
        $display("op %s a=%h b=%h result=%h latency=%0d", name, a, b, result, k);
        @(posedge clk); #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        instr = '0;
        op_a  = '0;
        op_b  = '0;

        // Per-cycle comparison of DUT outputs against the model.
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("cyc_busy", busy, m_left != 0);
                    chk("cyc_done", done, m_left == 1);
                    chk("cyc_result", result, m_res);
                    chk("cyc_md_req", md_req, m_is_md(instr));
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        @(posedge clk); #1;

        run_op("mul_7_m3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_ff",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_ff",     3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_5_0",    3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_5_0",     3'b110, 32'd5,          32'd0,         32'd5,         1);
        run_op("remu_100_7",  3'b111, 32'd100,        32'd7,         32'd2,         DIV_LAT);
        run_op("divu_ff_3",   3'b101, 32'hFFFF_FFFF,  32'd3,         32'h5555_5555, DIV_LAT);

        // Kill part-way through a divide: back to idle, result untouched.
        instr = mk_instr(3'b100);
        op_a  = 32'd1000;
        op_b  = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_busy", busy, 0);
        chk("kill_result", result, 32'h5555_5555);
        $display("op kill_div busy=%0b result=%h", busy, result);
        repeat (40) @(posedge clk);
        #1;
        run_op("div_after_kill", 3'b100, 32'd1000, 32'd3, 32'd333, DIV_LAT);

        // Start held high through the whole op with inputs changing after accept.
        instr = mk_instr(3'b000);
        op_a  = 32'd3;
        op_b  = 32'd4;
        start = 1'b1;
        @(posedge clk); #1;
        instr = mk_instr(3'b101);
        op_a  = 32'd100;
        op_b  = 32'd100;
        begin
            int k;
            bit seen;
            k    = 0;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                k++;
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            start = 1'b0;
            chk("held_latency", seen ? k : -1, MUL_LAT);
            chk("held_result", result, 32'd12);
            $display("op held_start_mul result=%h latency=%0d", result, k);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("held_idle_busy", busy, 0);
        @(posedge clk); #1;

        // ADD instruction is not an M op: no md_req, no accept.
        instr = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        op_a  = 32'd1;
        op_b  = 32'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("add_md_req", md_req, 0);
        chk("add_busy", busy, 0);
        $display("op add_ignored md_req=%0b busy=%0b", md_req, busy);
        @(posedge clk); #1;

        // Start and kill together in idle: kill wins.
        instr = mk_instr(3'b000);
        start = 1'b1;
        kill  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        kill  = 1'b0;
        @(negedge clk);
        chk("startkill_busy", busy, 0);
        $display("op start_with_kill busy=%0b", busy);
        @(posedge clk); #1;

        // Reset mid-multiply clears everything and yields no done.
        instr = mk_instr(3'b000);
        op_a  = 32'd9;
        op_b  = 32'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        $display("op reset_mid_mul busy=%0b result=%h", busy, result);
        @(posedge clk); #1;
        run_op("mul_after_rst", 3'b000, 32'd9, 32'd9, 32'd81, MUL_LAT);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
